// File: rtl/conv_accum.sv
// rtl/conv_accum.sv - signed Q8.10 multiply-accumulate with bias, rounding and saturation
module conv_accum #(
    parameter int DATA_LEN = 18,
    parameter int FRAC     = 10,
    parameter int N_TERMS  = 9,
    parameter int ACC_LEN  = 2*DATA_LEN+8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_LEN-1:0] bias,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] x,
    input  logic [DATA_LEN-1:0] w,
    output logic                busy,
    output logic                out_valid,
    output logic [DATA_LEN-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

    // Constants in the Q.20 accumulator domain / the shifted-down result domain
    localparam logic signed [ACC_LEN-1:0] HALF =
        {{(ACC_LEN-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [ACC_LEN-1:0] SAT_MAX =
        {{(ACC_LEN-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
    localparam logic signed [ACC_LEN-1:0] SAT_MIN =
        {{(ACC_LEN-DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};

    state_t                      state;
    logic signed [ACC_LEN-1:0]   acc;
    logic [7:0]                  cnt;

    logic signed [2*DATA_LEN-1:0] prod;
    logic signed [ACC_LEN-1:0]    prod_ext;
    logic signed [ACC_LEN-1:0]    bias_ext;
    logic signed [ACC_LEN-1:0]    acc_half;
    logic signed [ACC_LEN-1:0]    rnd;
    logic                         beat;

    assign prod     = $signed(x) * $signed(w);
    assign prod_ext = {{(ACC_LEN-2*DATA_LEN){prod[2*DATA_LEN-1]}}, prod};
    assign bias_ext = {{(ACC_LEN-DATA_LEN-FRAC){bias[DATA_LEN-1]}}, bias, {FRAC{1'b0}}};
    assign acc_half = acc + HALF;
    assign rnd      = acc_half >>> FRAC;

    assign in_ready = (state == ACC);
    assign busy     = (state != IDLE);
    assign beat     = in_valid && (state == ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= bias_ext;
                        cnt   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + 8'd1;
                        if (cnt == LAST_CNT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (rnd > SAT_MAX) begin
                        out_data <= {1'b0, {(DATA_LEN-1){1'b1}}};
                    end else if (rnd < SAT_MIN) begin
                        out_data <= {1'b1, {(DATA_LEN-1){1'b0}}};
                    end else begin
                        out_data <= rnd[DATA_LEN-1:0];
                    end
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_accum.sv
// tb/tb_conv_accum.sv - directed self-checking bench for conv_accum
module tb_conv_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [17:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] x;
    logic [17:0] w;
    logic        busy;
    logic        out_valid;
    logic [17:0] out_data;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    conv_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full result: start, nine beats, then exact strobe timing and value
    task automatic run(input string tag, input logic [17:0] b, input logic [17:0] xv,
                       input logic [17:0] wv, input bit stall, input bit junk,
                       input logic [17:0] exp);
        int p0;
        p0 = pulses;
        if (junk) begin
            in_valid = 1'b1; x = xv; w = wv;
            step();
            check({tag, "_idle_busy"}, 32'(busy), 32'd0);
            in_valid = 1'b0;
            step();
        end
        start = 1'b1; bias = b; in_valid = junk; x = xv; w = wv;
        step();
        start = 1'b0; in_valid = 1'b0;
        check({tag, "_ready_after_start"}, 32'(in_ready), 32'd1);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; x = xv; w = wv;
            if (junk && i == 2) start = 1'b1;
            step();
            start = 1'b0;
            if (stall && i == 3) begin
                in_valid = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    check({tag, "_ready_stall"}, 32'(in_ready), 32'd1);
                end
            end
        end
        in_valid = 1'b0;
        check({tag, "_done_no_strobe"}, 32'(out_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd1);
        step();
        check({tag, "_strobe"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        step();
        check({tag, "_strobe_low"}, 32'(out_valid), 32'd0);
        check({tag, "_data_hold"}, 32'(out_data), 32'(exp));
        check({tag, "_pulse_count"}, 32'(pulses - p0), 32'd1);
    endtask

    initial begin
        int p0;
        rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0; x = '0; w = '0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();

        run("basic",   18'h00000, 18'h00400, 18'h00400, 1'b0, 1'b0, 18'h02400);
        run("bias",    18'h3FC00, 18'h00200, 18'h00200, 1'b1, 1'b0, 18'h00500);
        run("sat_pos", 18'h00000, 18'h19000, 18'h00800, 1'b0, 1'b0, 18'h1FFFF);
        run("sat_neg", 18'h00000, 18'h19000, 18'h3F800, 1'b0, 1'b0, 18'h20000);
        run("rnd_pos", 18'h00000, 18'h00001, 18'h00200, 1'b0, 1'b0, 18'h00005);
        run("rnd_neg", 18'h00000, 18'h3FFFF, 18'h00200, 1'b0, 1'b0, 18'h3FFFC);
        run("ignored", 18'h00000, 18'h00400, 18'h00400, 1'b0, 1'b1, 18'h02400);

        // Reset partway through an accumulation
        p0 = pulses;
        start = 1'b1; bias = '0;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; x = 18'h00400; w = 18'h00400;
            step();
        end
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("midrst_no_strobe", 32'(pulses - p0), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        run("after_rst", 18'h00000, 18'h00400, 18'h00400, 1'b0, 1'b0, 18'h02400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_accum.md
# conv_accum

Signed fixed-point multiply-accumulate stage that produces the pre-activation value for one output neuron and sits directly upstream of the ELU lookup stage. It accumulates `N_TERMS` products of 18-bit Q8.10 activations and weights onto a Q8.10 bias, then rounds and saturates the sum back to Q8.10. The result is presented as a single-cycle `out_valid` pulse, and the ELU stage consumes `out_data` as its `d` input.

## Interface
- `DATA_LEN`, default 18: operand/result width, signed two's complement Q8.10.
- `FRAC`, default 10: fractional bits of operands and result.
- `N_TERMS`, default 9: products per result (3x3 kernel); legal range 1..255.
- `ACC_LEN`, default 44: accumulator width, `2*DATA_LEN+8`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a new result; sampled only in IDLE.
- `bias` in DATA_LEN: Q8.10 bias, sampled with `start`.
- `in_valid` in 1: `x`/`w` beat present.
- `in_ready` out 1: high exactly when state is ACC; a beat transfers on `in_valid & in_ready`.
- `x` in DATA_LEN: Q8.10 activation.
- `w` in DATA_LEN: Q8.10 weight.
- `busy` out 1: high whenever state is not IDLE.
- `out_valid` out 1: one-cycle result strobe.
- `out_data` out DATA_LEN: Q8.10 rounded, saturated result; holds its value until the next strobe.

## Operation
- States are IDLE, ACC and DONE.
- **IDLE**
  - `start=1`: `acc <= sign_ext(bias) << FRAC` (Q.20 domain), `cnt <= 0`, go to ACC.
  - `in_valid` is ignored in IDLE. If `start` and `in_valid` are both high in IDLE, only the `start` takes effect and that beat is not consumed.
- **ACC**
  - Each transferred beat: `acc <= acc + sign_ext(x*w)`, where the product is a full 36-bit signed value; then `cnt <= cnt+1`.
  - Cycles with `in_valid=0` are stalls: acc and cnt hold, with no timeout.
  - When the beat that makes `cnt == N_TERMS` transfers, go to DONE.
  - `start` is ignored in ACC.
- **DONE** (one cycle)
  - `r = (acc + (1 << (FRAC-1))) >>> FRAC`, an arithmetic shift giving round-half-up (toward +inf on exact halves).
  - If `r > 2^(DATA_LEN-1)-1`, `out_data <= 18'h1FFFF`. If `r < -2^(DATA_LEN-1)`, `out_data <= 18'h20000`. Otherwise `out_data <= r[DATA_LEN-1:0]`.
  - `out_valid <= 1`, go to IDLE.
  - `start` is ignored in DONE.
- Accumulator overflow cannot occur within the legal `N_TERMS` range; no wrap handling is needed.
- No output backpressure: the downstream stage accepts every strobe.

## Timing
- Reset values: state IDLE, `acc=0`, `cnt=0`, `out_valid=0`, `out_data=0`, `in_ready=0`, `busy=0`.
- `in_ready` and `busy` are combinational from state.
- `start` sampled at edge S: `in_ready=1` from the cycle after S. The first beat can transfer at edge S+1.
- Last beat transferred at edge E: DONE during the cycle after E. `out_valid=1` for exactly the cycle after edge E+1. `busy` drops at edge E+1.
- Minimum start-to-start period is `N_TERMS+2` cycles. `start` may be high in the same cycle `out_valid` is high, since the state is already IDLE.
- `rst_n` low mid-operation: all registers return to reset values immediately.
  - A partially accumulated result is discarded and no `out_valid` is produced for it.
  - After release, the block waits in IDLE for `start`.

## Test plan
- **Basic sum:** bias=18'h00000, nine beats of x=18'h00400 (1.0) and w=18'h00400, `in_valid` held high. Expect `out_data=18'h02400` (9.0), `out_valid` high for one cycle, two edges after the ninth beat.
- **Bias and fractions with stalls:** bias=18'h3FC00 (-1.0), nine beats of x=18'h00200 (0.5) and w=18'h00200, with `in_valid` low for 3 cycles between beats 4 and 5. Expect `out_data=18'h00500` (1.25); `in_ready` high throughout ACC.
- **Saturation:** bias 0, nine beats of x=18'h19000 (100.0) and w=18'h00800 (2.0) gives `out_data=18'h1FFFF`. The same run with w=18'h3F800 (-2.0) gives `out_data=18'h20000`.
- **Rounding:** bias 0, nine beats of x=18'h00001 and w=18'h00200 (sum is 4.5 LSB) gives `out_data=18'h00005`. Nine beats of x=18'h3FFFF and w=18'h00200 (sum is -4.5 LSB) gives `out_data=18'h3FFFC` (-4 LSB).
- **Ignored inputs:** `in_valid` pulses in IDLE before `start`, `start` pulsed during ACC, and `start` and `in_valid` high together in IDLE. Expect the result of test 1 unchanged (`18'h02400`) and exactly one `out_valid` pulse.
- **Reset mid-run:** assert `rst_n=0` after 4 of 9 beats. Expect all outputs 0 and no strobe. After release, a full test-1 sequence yields `18'h02400`.
